// File: rtl/arb_pkg.sv
// Shared types and helpers for the packet-lock arbiter stage.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Width of a binary index into n requesters; never below one bit.
  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_grant_lock_onehot_enc.sv
// One-hot to binary index encoder; all-zero input encodes to 0.
module onehot_enc
  import arb_pkg::*;
#(
  parameter int unsigned SIZE = 4,
  localparam int unsigned IdxW = arb_idx_w(SIZE)
) (
  input  logic [SIZE-1:0] oh_i,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (oh_i[i]) idx_o = idx_o | IdxW'(i);
    end
  end

endmodule

// File: rtl/arb_grant_lock.sv
// Packet-lock stage: arbitrates via an external priority arbiter, then holds the
// output channel for the winner until its last beat. GRANT_LOCK_B2B_EN enables
// re-arbitration during the last-beat handshake so packets can run back to back.
module arb_grant_lock
  import arb_pkg::*;
#(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned IdxW  = arb_idx_w(SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SIZE-1:0]          in_valid,
  input  logic [SIZE-1:0]          in_last,
  input  logic [SIZE*DATA_W-1:0]   in_data,
  output logic [SIZE-1:0]          in_ready,
  output logic [SIZE-1:0]          arb_req,
  input  logic [SIZE-1:0]          arb_gnt,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [IdxW-1:0]          owner_idx,
  output logic                     busy
);

  arb_state_e      state_q, state_d;
  logic [SIZE-1:0] owner_q, owner_d;
  logic [IdxW-1:0] owner_idx_q, owner_idx_d;
  logic [IdxW-1:0] gnt_idx;
  logic            hs_last;

  onehot_enc #(
    .SIZE (SIZE)
  ) u_enc (
    .oh_i  (arb_gnt),
    .idx_o (gnt_idx)
  );

  // Datapath is a pure mux of the owner's lane; nothing is buffered.
  always_comb begin
    arb_req   = '0;
    in_ready  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    hs_last   = 1'b0;
    if (!rst) begin
      if (state_q == ARB_IDLE) begin
        arb_req = in_valid;
      end else begin
        out_valid = in_valid[owner_idx_q];
        out_last  = in_last[owner_idx_q];
        out_data  = in_data[owner_idx_q*DATA_W +: DATA_W];
        in_ready  = owner_q & {SIZE{out_ready}};
        hs_last   = out_valid & out_ready & out_last;
`ifdef GRANT_LOCK_B2B_EN
        // Departing owner is masked so it cannot win the next packet.
        if (hs_last) arb_req = in_valid & ~owner_q;
`endif
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    owner_idx_d = owner_idx_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|arb_gnt) begin
          state_d     = ARB_LOCKED;
          owner_d     = arb_gnt;
          owner_idx_d = gnt_idx;
        end
      end
      ARB_LOCKED: begin
        if (hs_last) begin
`ifdef GRANT_LOCK_B2B_EN
          if (|arb_gnt) begin
            owner_d     = arb_gnt;
            owner_idx_d = gnt_idx;
          end else begin
            state_d     = ARB_IDLE;
            owner_d     = '0;
            owner_idx_d = '0;
          end
`else
          state_d     = ARB_IDLE;
          owner_d     = '0;
          owner_idx_d = '0;
`endif
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        owner_d     = '0;
        owner_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      owner_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      owner_idx_q <= owner_idx_d;
    end
  end

  assign busy      = (state_q == ARB_LOCKED);
  assign owner_idx = owner_idx_q;

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(arb_gnt));

endmodule

// File: tb/tb_arb_grant_lock.sv
// Randomized bench for arb_grant_lock with an LSB-first arbiter on arb_req/arb_gnt,
// checked every cycle against a packet-level ownership model.
module tb_arb_grant_lock;

  localparam int unsigned SIZE   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NCYC   = 2000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [SIZE-1:0]        in_valid;
  logic [SIZE-1:0]        in_last;
  logic [SIZE*DATA_W-1:0] in_data;
  logic [SIZE-1:0]        in_ready;
  logic [SIZE-1:0]        arb_req;
  logic [SIZE-1:0]        arb_gnt;
  logic                   out_valid;
  logic                   out_last;
  logic [DATA_W-1:0]      out_data;
  logic                   out_ready;
  logic [1:0]             owner_idx;
  logic                   busy;

  always #5 clk = ~clk;

  // LSB-first priority arbiter: isolate lowest set request bit.
  always_comb arb_gnt = arb_req & (~arb_req + 4'd1);

  arb_grant_lock #(
    .SIZE   (SIZE),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .arb_req   (arb_req),
    .arb_gnt   (arb_gnt),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .owner_idx (owner_idx),
    .busy      (busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [SIZE-1:0] v);
    for (int i = 0; i < SIZE; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: who owns the channel, and each source's packet progress.
  bit          m_locked;
  int          m_owner;
  int unsigned rem [SIZE];
  int unsigned seq [SIZE];

  logic [SIZE-1:0]   e_req, e_rdy;
  logic              e_ov, e_ol, e_busy, e_hs_last;
  logic [DATA_W-1:0] e_od;
  logic [1:0]        e_idx;
  logic [SIZE-1:0]   others;
  bit                b2b;

  initial begin
`ifdef GRANT_LOCK_B2B_EN
    b2b = 1'b1;
`else
    b2b = 1'b0;
`endif
    m_locked  = 1'b0;
    m_owner   = 0;
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      rem[i] = $urandom_range(1, 4);
      seq[i] = 0;
    end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst = (c < 3) || (c >= 400 && c < 402) || (c == 1200);
      for (int i = 0; i < SIZE; i++) begin
        in_valid[i] = (c <= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_last[i]  = (rem[i] == 1);
        in_data[i*DATA_W +: DATA_W] = {8'(i), seq[i][23:0]};
      end
      out_ready = (c < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      #1;

      e_req = '0; e_rdy = '0; e_ov = 1'b0; e_ol = 1'b0; e_od = '0;
      e_busy = 1'b0; e_idx = '0; e_hs_last = 1'b0;
      others = '0;
      if (!rst) begin
        if (!m_locked) begin
          e_req = in_valid;
        end else begin
          e_busy = 1'b1;
          e_idx  = 2'(m_owner);
          e_ov   = in_valid[m_owner];
          e_ol   = in_last[m_owner];
          e_od   = in_data[m_owner*DATA_W +: DATA_W];
          e_rdy  = out_ready ? SIZE'(1 << m_owner) : '0;
          e_hs_last = e_ov && e_ol && out_ready;
          others = in_valid & ~SIZE'(1 << m_owner);
          if (b2b && e_hs_last) e_req = others;
        end
      end

      check_eq("arb_req",   arb_req,   e_req);
      check_eq("in_ready",  in_ready,  e_rdy);
      check_eq("out_valid", out_valid, e_ov);
      check_eq("out_last",  out_last,  e_ol);
      check_eq("out_data",  out_data,  e_od);
      check_eq("busy",      busy,      e_busy);
      check_eq("owner_idx", owner_idx, e_idx);

      // Advance sources on accepted beats, then the ownership model.
      if (!rst) begin
        for (int i = 0; i < SIZE; i++) begin
          if (e_rdy[i] && in_valid[i]) begin
            seq[i]++;
            rem[i]--;
            if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          end
        end
      end
      if (rst) begin
        m_locked = 1'b0;
      end else if (!m_locked) begin
        if (in_valid != '0) begin
          m_locked = 1'b1;
          m_owner  = lowest(in_valid);
        end
      end else if (e_hs_last) begin
        if (b2b && others != '0) m_owner = lowest(others);
        else m_locked = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
